// File: rtl/moore_seq_engine.sv
// Runtime-programmable one-hot Moore sequencer. Each state selects one input
// bit, branches to a programmable true/false successor after a programmable
// minimum dwell, and drives a programmable output word. Illegal one-hot codes
// and out-of-range targets recover to S0 and raise a sticky error flag.
module moore_seq_engine #(
  parameter int NUM_STATES = 4,
  parameter int NUM_IN     = 4,
  parameter int OUT_W      = 2,
  parameter int DWELL_W    = 4,
  localparam int ST_W      = $clog2(NUM_STATES),
  localparam int SEL_W     = $clog2(NUM_IN),
  localparam int CFG_W     = SEL_W + 2*ST_W + OUT_W + DWELL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_IN-1:0]     X,
  input  logic                  cfg_we,
  input  logic [ST_W-1:0]       cfg_addr,
  input  logic [CFG_W-1:0]      cfg_data,
  output logic [OUT_W-1:0]      Z,
  output logic [NUM_STATES-1:0] state_oh,
  output logic                  trans,
  output logic                  err
);

  // Bit offsets of the fields inside one table entry {dwell, z, next_f, next_t, in_sel}.
  localparam int T_LO = SEL_W;
  localparam int F_LO = SEL_W + ST_W;
  localparam int Z_LO = SEL_W + 2*ST_W;
  localparam int D_LO = Z_LO + OUT_W;

  function automatic logic [2**ST_W-1:0] stateMask();
    logic [2**ST_W-1:0] m;
    for (int i = 0; i < 2**ST_W; i++) m[i] = (i < NUM_STATES);
    return m;
  endfunction

  function automatic logic [2**SEL_W-1:0] selMask();
    logic [2**SEL_W-1:0] m;
    for (int i = 0; i < 2**SEL_W; i++) m[i] = (i < NUM_IN);
    return m;
  endfunction

  function automatic logic [CFG_W-1:0] defaultEntry(int i);
    return {DWELL_W'(0), OUT_W'(i), ST_W'(i), ST_W'((i + 1) % NUM_STATES), SEL_W'(i % NUM_IN)};
  endfunction

  // Encodable indices that name a real state / a real input bit.
  localparam logic [2**ST_W-1:0]  ST_VALID  = stateMask();
  localparam logic [2**SEL_W-1:0] SEL_VALID = selMask();

  logic [CFG_W-1:0]      cfg_q [NUM_STATES];
  logic [NUM_STATES-1:0] state_q, state_d;
  logic [DWELL_W-1:0]    dwell_q, dwell_d;
  logic                  trans_q, trans_d;
  logic                  err_q, err_d;

  logic [ST_W-1:0]    curIdx;
  logic               stateLegal;
  logic [CFG_W-1:0]   curEntry;
  logic [SEL_W-1:0]   curSel;
  logic [ST_W-1:0]    tgt;

  // Decode the one-hot state into an index and fetch its table entry.
  always_comb begin
    curIdx = '0;
    for (int i = 0; i < NUM_STATES; i++) begin
      if (state_q[i]) curIdx = ST_W'(i);
    end
    stateLegal = $onehot(state_q);
    curEntry   = cfg_q[curIdx];
    curSel     = SEL_VALID[curEntry[SEL_W-1:0]] ? curEntry[SEL_W-1:0] : '0;
    tgt        = X[curSel] ? curEntry[T_LO +: ST_W] : curEntry[F_LO +: ST_W];
  end

  // Moore output depends only on state and table; blanked while the state is illegal.
  always_comb begin
    Z = '0;
    if (stateLegal) Z = curEntry[Z_LO +: OUT_W];
  end

  // Next-state, dwell counting, transition strobe and error recovery.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    trans_d = 1'b0;
    err_d   = err_q;
    if (!stateLegal) begin
      state_d = NUM_STATES'(1);
      dwell_d = '0;
      err_d   = 1'b1;
    end else if (en) begin
      if (dwell_q < curEntry[D_LO +: DWELL_W]) begin
        dwell_d = dwell_q + DWELL_W'(1);
      end else if (!ST_VALID[tgt]) begin
        state_d = NUM_STATES'(1);
        dwell_d = '0;
        trans_d = 1'b1;
        err_d   = 1'b1;
      end else if (tgt != curIdx) begin
        state_d = NUM_STATES'(1) << tgt;
        dwell_d = '0;
        trans_d = 1'b1;
      end
    end
  end

  // State, dwell counter, strobe and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= NUM_STATES'(1);
      dwell_q <= '0;
      trans_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      trans_q <= trans_d;
      err_q   <= err_d;
    end
  end

  // Transition table: reset to the default ring, written by the config port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_STATES; i++) cfg_q[i] <= defaultEntry(i);
    end else if (cfg_we && ST_VALID[cfg_addr]) begin
      cfg_q[cfg_addr] <= cfg_data;
    end
  end

  assign state_oh = state_q;
  assign trans    = trans_q;
  assign err      = err_q;

endmodule

// File: tb/tb_moore_seq_engine.sv
// Directed bench for moore_seq_engine with hand-computed expectations.
module tb_moore_seq_engine;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  X;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [11:0] cfg_data;
  logic [1:0]  Z;
  logic [3:0]  state_oh;
  logic        trans;
  logic        err;

  int checks = 0;
  int errors = 0;

  moore_seq_engine dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .X        (X),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .Z        (Z),
    .state_oh (state_oh),
    .trans    (trans),
    .err      (err)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  task automatic applyStimulus(input logic enV, input logic [3:0] xV);
    en = enV;
    X  = xV;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic writeEntry(input logic [1:0] addr, input logic [11:0] data);
    en       = 1'b0;
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    tick(1);
    cfg_we   = 1'b0;
  endtask

  task automatic pulseReset();
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
  endtask

  // Directed sequence; table entries are {dwell[11:8], z[7:6], next_f[5:4], next_t[3:2], in_sel[1:0]}.
  initial begin
    rst = 1'b0; en = 1'b0; X = 4'b0000; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 12'h000;
    tick(2);
    checkOutput("rst_state", 32'(state_oh), 32'h1);
    checkOutput("rst_z",     32'(Z),        32'h0);
    checkOutput("rst_trans", 32'(trans),    32'h0);
    checkOutput("rst_err",   32'(err),      32'h0);
    rst = 1'b1;

    // Default ring: S0 tests X0, true goes to S1.
    applyStimulus(1'b1, 4'b0001);
    checkOutput("t1_z_pre", 32'(Z), 32'h0);
    tick(1);
    checkOutput("t1_state", 32'(state_oh), 32'h2);
    checkOutput("t1_trans", 32'(trans),    32'h1);
    checkOutput("t1_z",     32'(Z),        32'h1);
    tick(1);
    checkOutput("t1_stay_state", 32'(state_oh), 32'h2);
    checkOutput("t1_stay_trans", 32'(trans),    32'h0);

    // Minimum dwell of 3 in S0.
    en = 1'b0;
    pulseReset();
    writeEntry(2'd0, 12'h304);
    applyStimulus(1'b1, 4'b0001);
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      checkOutput($sformatf("t2_dwell_state%0d", i), 32'(state_oh), 32'h1);
      checkOutput($sformatf("t2_dwell_trans%0d", i), 32'(trans),    32'h0);
    end
    tick(1);
    checkOutput("t2_state", 32'(state_oh), 32'h2);
    checkOutput("t2_trans", 32'(trans),    32'h1);

    // Programmed table walk S0 -> S1 -> S2 -> S3 -> S1.
    en = 1'b0;
    pulseReset();
    writeEntry(2'd0, 12'h044);
    writeEntry(2'd1, 12'h0A1);
    writeEntry(2'd2, 12'h06E);
    writeEntry(2'd3, 12'h0C7);
    checkOutput("t3_z_s0", 32'(Z), 32'h1);
    applyStimulus(1'b1, 4'b0001); tick(1);
    checkOutput("t3_s1", 32'(state_oh), 32'h2);
    checkOutput("t3_z_s1", 32'(Z), 32'h2);
    applyStimulus(1'b1, 4'b0000); tick(1);
    checkOutput("t3_s2", 32'(state_oh), 32'h4);
    checkOutput("t3_z_s2", 32'(Z), 32'h1);
    applyStimulus(1'b1, 4'b0100); tick(1);
    checkOutput("t3_s3", 32'(state_oh), 32'h8);
    checkOutput("t3_z_s3", 32'(Z), 32'h3);
    applyStimulus(1'b1, 4'b1000); tick(1);
    checkOutput("t3_s1b", 32'(state_oh), 32'h2);
    checkOutput("t3_z_s1b", 32'(Z), 32'h2);
    checkOutput("t3_trans", 32'(trans), 32'h1);

    // Enable low freezes the machine.
    applyStimulus(1'b0, 4'b1111);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checkOutput($sformatf("t4_hold_trans%0d", i), 32'(trans), 32'h0);
    end
    checkOutput("t4_hold_state", 32'(state_oh), 32'h2);
    checkOutput("t4_hold_z",     32'(Z),        32'h2);
    applyStimulus(1'b1, 4'b1111); tick(1);
    checkOutput("t4_run_state", 32'(state_oh), 32'h1);
    checkOutput("t4_run_trans", 32'(trans),    32'h1);

    // Same-edge rewrite of the active entry: evaluation uses the old entry (next_t=S1).
    applyStimulus(1'b1, 4'b0001);
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 12'h04C;
    tick(1);
    cfg_we = 1'b0;
    en     = 1'b0;
    checkOutput("wr_old_entry", 32'(state_oh), 32'h2);

    // Illegal one-hot code recovers to S0 and sets the sticky error.
    force dut.state_q = 4'b0110;
    #1;
    checkOutput("t5_forced_state", 32'(state_oh), 32'h6);
    checkOutput("t5_forced_z",     32'(Z),        32'h0);
    @(posedge clk);
    #1;
    release dut.state_q;
    checkOutput("t5_err_set", 32'(err),   32'h1);
    checkOutput("t5_trans",   32'(trans), 32'h0);
    @(negedge clk);
    tick(1);
    checkOutput("t5_recovered", 32'(state_oh), 32'h1);
    applyStimulus(1'b1, 4'b0000); tick(2);
    checkOutput("t5_err_sticky", 32'(err), 32'h1);

    // Asynchronous reset in the middle of a dwell, then defaults return.
    writeEntry(2'd0, 12'h044);
    writeEntry(2'd2, 12'h26E);
    applyStimulus(1'b1, 4'b0001); tick(1);
    checkOutput("t6_s1", 32'(state_oh), 32'h2);
    applyStimulus(1'b1, 4'b0000); tick(1);
    checkOutput("t6_s2", 32'(state_oh), 32'h4);
    tick(2);
    checkOutput("t6_dwell_state", 32'(state_oh), 32'h4);
    checkOutput("t6_dwell_z",     32'(Z),        32'h1);
    #2 rst = 1'b0;
    #1;
    checkOutput("t6_rst_state", 32'(state_oh), 32'h1);
    checkOutput("t6_rst_z",     32'(Z),        32'h0);
    checkOutput("t6_rst_err",   32'(err),      32'h0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 4'b0001); tick(1);
    checkOutput("t6_def_s1", 32'(state_oh), 32'h2);
    checkOutput("t6_def_z1", 32'(Z),        32'h1);
    applyStimulus(1'b1, 4'b0010); tick(1);
    checkOutput("t6_def_s2", 32'(state_oh), 32'h4);
    checkOutput("t6_def_z2", 32'(Z),        32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
